// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined two-level carry-lookahead adder/subtractor.
// Each stage adds one slice of 4-bit groups and registers its carry-out.
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / 4;
  localparam int L  = STAGES - 1;

  function automatic logic [1:0] grp_gp(
    input logic [3:0] x,
    input logic [3:0] y
  );
    logic [3:0] p, g;
    logic       gg;
    p  = x ^ y;
    g  = x & y;
    gg = g[3]
       | (p[3] & g[2])
       | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

  function automatic logic [3:0] grp_add(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] p, g, c;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    return p ^ c;
  endfunction

  // Returns {slice carry-out, slice sum}.
  function automatic logic [SW:0] slice_add(
    input logic [SW-1:0] x,
    input logic [SW-1:0] y,
    input logic          ci
  );
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic [SW-1:0] s;
    logic          acc_g, acc_p;
    for (int k = 0; k < NG; k++)
      {gg[k], gp[k]} = grp_gp(x[4*k+:4], y[4*k+:4]);
    gc[0] = ci;
    for (int k = 1; k <= NG; k++) begin
      acc_g = 1'b0;
      acc_p = 1'b1;
      for (int j = k - 1; j >= 0; j--) begin
        acc_g = acc_g | (acc_p & gg[j]);
        acc_p = acc_p & gp[j];
      end
      gc[k] = acc_g | (acc_p & ci);
    end
    s = '0;
    for (int k = 0; k < NG; k++)
      s[4*k+:4] = grp_add(x[4*k+:4], y[4*k+:4], gc[k]);
    return {gc[NG], s};
  endfunction

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * SW;
    localparam int HW = WIDTH - (s + 1) * SW;

    logic [WIDTH-1:0]    xs;
    logic [WIDTH-LO-1:0] bin;
    logic [SW-1:0]       ys;
    logic                cs, vs;
    logic [SW:0]         r;
    logic [WIDTH-1:0]    x_d, x_q;
    logic                c_d, c_q;
    logic                v_d, v_q;

    if (s == 0) begin : g_src
      assign xs  = a;
      assign bin = sub ? ~b : b;
      assign cs  = cin;
      assign vs  = in_valid;
    end else begin : g_src
      assign xs  = g_st[s-1].x_q;
      assign bin = g_st[s-1].g_b.b_q;
      assign cs  = g_st[s-1].c_q;
      assign vs  = g_st[s-1].v_q;
    end

    assign ys = bin[SW-1:0];

    // x carries finished sum bits below the slice, raw A above it.
    always_comb begin
      r           = slice_add(xs[LO+:SW], ys, cs);
      x_d         = xs;
      x_d[LO+:SW] = r[SW-1:0];
      c_d         = r[SW];
      v_d         = vs;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        x_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (adv) begin
        x_q <= x_d;
        c_q <= c_d;
        v_q <= v_d;
      end
    end

    if (s < L) begin : g_b
      logic [HW-1:0] b_d, b_q;
      assign b_d = bin[WIDTH-LO-1:SW];
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      b_q <= '0;
        else if (adv) b_q <= b_d;
      end
    end

    if (s == L) begin : g_o
      logic o_d, o_q;
      // Carry into the MSB recovered as a ^ b ^ sum at that bit.
      assign o_d = xs[WIDTH-1] ^ ys[SW-1]
                 ^ r[SW-1] ^ r[SW];
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      o_q <= 1'b0;
        else if (adv) o_q <= o_d;
      end
    end
  end

  assign sum       = g_st[L].x_q;
  assign cout      = g_st[L].c_q;
  assign out_valid = g_st[L].v_q;
  assign ovf       = g_st[L].g_o.o_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: several WIDTH/STAGES builds driven in lockstep,
// checked against an arithmetic reference with per-build scoreboards.
module tb_cla_pipe_adder;
  localparam int N = 8;

  function automatic int ws(int i);
    case (i)
      0, 1:    return 32;
      2, 3:    return 8;
      4, 5:    return 16;
      default: return 64;
    endcase
  endfunction

  function automatic int ss(int i);
    case (i)
      0:       return 2;
      1:       return 4;
      2, 4, 6: return 1;
      3:       return 2;
      5:       return 4;
      default: return 16;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst, in_valid, out_ready, cin, sub;
  logic [63:0] a_in, b_in;
  logic [N-1:0] ir, ov, co, of;
  logic [N-1:0][63:0] so;

  always #5 clk = ~clk;

  for (genvar i = 0; i < N; i++) begin : g_dut
    localparam int W = ws(i);
    logic [W-1:0] s_w;
    cla_pipe_adder #(.WIDTH(W), .STAGES(ss(i))) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (ir[i]),
      .a        (a_in[W-1:0]),
      .b        (b_in[W-1:0]),
      .cin      (cin),
      .sub      (sub),
      .out_valid(ov[i]),
      .out_ready(out_ready),
      .sum      (s_w),
      .cout     (co[i]),
      .ovf      (of[i])
    );
    assign so[i] = 64'(s_w);
  end

  int n_run, n_fail;

  task automatic check(string tag, logic [65:0] got,
                       logic [65:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum} from plain w-bit arithmetic and the sign rule.
  function automatic logic [65:0] model(int w, logic [63:0] x,
                                        logic [63:0] y,
                                        logic ci, logic sb);
    logic [64:0] mask, ea, eb, t;
    logic [63:0] s;
    logic        v;
    mask = (65'd1 << w) - 65'd1;
    ea   = {1'b0, x} & mask;
    eb   = {1'b0, (sb ? ~y : y)} & mask;
    t    = ea + eb + {64'd0, ci};
    s    = t[63:0] & mask[63:0];
    v    = (ea[w-1] == eb[w-1]) && (s[w-1] != ea[w-1]);
    return {v, t[w], s};
  endfunction

  logic [65:0] sbq [N][$];

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) sbq[i].delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ov[i] && out_ready) begin
          if (sbq[i].size() == 0)
            check($sformatf("sb%0d_extra", i),
                  66'(sbq[i].size()), 66'd1);
          else
            check($sformatf("sb%0d", i),
                  {of[i], co[i], so[i]}, sbq[i].pop_front());
        end
        if (in_valid && ir[i])
          sbq[i].push_back(model(ws(i), a_in, b_in, cin, sub));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [63:0] x, logic [63:0] y,
                     logic ci, logic sb);
    a_in     = x;
    b_in     = y;
    cin      = ci;
    sub      = sb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int nin, nout;
    logic [63:0] got [8];
    logic [63:0] held;
    n_run = 0;
    n_fail = 0;
    held = '0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cin = 1'b0;
    sub = 1'b0;
    a_in = '0;
    b_in = '0;
    #12;
    check("rst_valid", 66'(ov), 66'd0);
    check("rst_data", {of[0], co[0], so[0]}, 66'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    step();
    check("rst_ready", 66'(ir), 66'({N{1'b1}}));

    put(64'hFFFF_FFFF, 64'd1, 1'b0, 1'b0);
    step();
    check("add_v", 66'(ov[0]), 66'd1);
    check("add_wrap", {of[0], co[0], so[0]},
          {1'b0, 1'b1, 64'h0});

    put(64'h8000_0000, 64'd1, 1'b1, 1'b1);
    step();
    check("sub_ovf", {of[0], co[0], so[0]},
          {1'b1, 1'b1, 64'h7FFF_FFFF});
    put(64'd5, 64'd7, 1'b1, 1'b1);
    step();
    check("sub_neg", {of[0], co[0], so[0]},
          {1'b0, 1'b0, 64'hFFFF_FFFE});

    repeat (6) step();
    put(64'hFFFF, 64'd1, 1'b0, 1'b0);
    for (int j = 1; j < 4; j++) begin
      check("lat4_early", 66'(ov[1]), 66'd0);
      step();
    end
    check("lat4_v", 66'(ov[1]), 66'd1);
    check("lat4_sum", {of[1], co[1], so[1]}, 66'h1_0000);

    repeat (20) step();
    nin = 0;
    nout = 0;
    for (int cyc = 0; cyc < 40 && nout < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc < 7);
      in_valid  = (nin < 8);
      a_in      = 64'(nin);
      b_in      = 64'(nin) << 16;
      cin       = 1'b0;
      sub       = 1'b0;
      @(negedge clk);
      if (!out_ready) begin
        check("bp_ready", 66'(ir[0]), 66'd0);
        check("bp_valid", 66'(ov[0]), 66'd1);
        if (cyc == 4) held = so[0];
        else check("bp_hold", 66'(so[0]), 66'(held));
      end
      if (ov[0] && out_ready) begin
        if (nout < 8) got[nout] = so[0];
        nout++;
      end
      if (in_valid && ir[0]) nin++;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_count", 66'(nout), 66'd8);
    for (int j = 0; j < 8; j++)
      check($sformatf("bp_order%0d", j), 66'(got[j]),
            66'(j + (j << 16)));

    repeat (20) step();
    put(64'h1234, 64'h1, 1'b0, 1'b0);
    put(64'h5678, 64'h1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check("arst_drop", 66'(ov), 66'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      step();
      check("arst_stale", 66'(ov), 66'd0);
    end
    check("arst_ready", 66'(ir), 66'({N{1'b1}}));

    for (int c = 0; c < 800; c++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      a_in      = {$urandom, $urandom};
      b_in      = {$urandom, $urandom};
      if ($urandom_range(3) == 0) b_in = ~a_in;
      if ($urandom_range(7) == 0) a_in = '1;
      cin = 1'($urandom);
      sub = 1'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (24) step();
    for (int i = 0; i < N; i++)
      check($sformatf("drain%0d", i),
            66'(sbq[i].size()), 66'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
